e_cmp_sched: RTL and testbench

- Shares one registered E-gap compare stage (E_del vs M_del max, plus traceback code) among NUM_REQ processing-element row requesters.
- Sits between the PE columns of the CIGAR extension array and the traceback writer.
- Arbitrates round-robin; a row burst is locked to one requester until its last cell.
- Results return with requester ID under valid/ready backpressure.

---
 rtl/e_cmp_sched.sv | 193 +++++++++++++++++++
 tb/tb_e_cmp_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_cmp_sched.sv
// ============================================================================
//  Module   : e_cmp_sched
//  Brief    : Round-robin scheduler sharing one registered E_del/M_del max
//             stage (with traceback code) among NUM_REQ PE-row requesters.
//             Optional macro E_SCHED_STALL_CNT_EN builds the stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_cmp_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BT_WIDTH   = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_e_del,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_m_del,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_max,
    output logic [BT_WIDTH-1:0]           rsp_d,
    output logic                          rsp_last,
    output logic                          busy,
    output logic [15:0]                   rows_done,
    output logic [15:0]                   stall_cnt
);

    localparam logic [0:0]          c_ST_IDLE = 1'b0;
    localparam logic [0:0]          c_ST_LOCK = 1'b1;
    localparam logic [BT_WIDTH-1:0] c_D_DEL   = BT_WIDTH'(4);

    logic [0:0]                   r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]          r_owner, w_owner_nxt;
    logic [ID_WIDTH-1:0]          r_rr_ptr, w_rr_ptr_nxt;
    logic [ID_WIDTH-1:0]          w_gnt_idx;
    logic                         w_gnt_any;
    logic                         w_can_issue;
    logic                         w_accept;
    logic                         w_acc_last;
    logic signed [DATA_WIDTH-1:0] w_e [NUM_REQ];
    logic signed [DATA_WIDTH-1:0] w_m [NUM_REQ];
    logic signed [DATA_WIDTH-1:0] w_sel_e, w_sel_m;

    logic                         r_rsp_valid;
    logic [ID_WIDTH-1:0]          r_rsp_id;
    logic [DATA_WIDTH-1:0]        r_rsp_max;
    logic [BT_WIDTH-1:0]          r_rsp_d;
    logic                         r_rsp_last;
    logic [15:0]                  r_rows_done;

    function automatic logic [ID_WIDTH-1:0] f_wrap(input int v);
        return ID_WIDTH'(v % NUM_REQ);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_e[gi] = req_e_del[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_m[gi] = req_m_del[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Descending scan so the lowest offset from rr_ptr wins the last write.
    always_comb begin : arb
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (r_state == c_ST_LOCK) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = r_owner;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[f_wrap(int'(r_rr_ptr) + k)]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = f_wrap(int'(r_rr_ptr) + k);
                end
            end
        end
    end

    assign w_can_issue = !r_rsp_valid || rsp_ready;
    assign w_accept    = w_gnt_any && w_can_issue && req_valid[w_gnt_idx];
    assign w_acc_last  = req_last[w_gnt_idx];
    assign w_sel_e     = w_e[w_gnt_idx];
    assign w_sel_m     = w_m[w_gnt_idx];

    always_ff @(posedge clk) begin : fsm_reg
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin : fsm_nxt
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_acc_last) begin
                        w_rr_ptr_nxt = f_wrap(int'(w_gnt_idx) + 1);
                    end else begin
                        w_state_nxt = c_ST_LOCK;
                        w_owner_nxt = w_gnt_idx;
                    end
                end
            end
            c_ST_LOCK: begin
                if (w_accept && w_acc_last) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_rr_ptr_nxt = f_wrap(int'(r_owner) + 1);
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin : fsm_out
        req_ready = '0;
        if (w_gnt_any && w_can_issue) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
        busy = (r_state == c_ST_LOCK) || r_rsp_valid;
    end

    // Tie goes to M: only a strictly larger E is reported as a deletion.
    always_ff @(posedge clk) begin : rsp_reg
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_max   <= '1;
            r_rsp_d     <= '1;
            r_rsp_last  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt_idx;
            r_rsp_last  <= w_acc_last;
            if (w_sel_e > w_sel_m) begin
                r_rsp_max <= w_sel_e;
                r_rsp_d   <= c_D_DEL;
            end else begin
                r_rsp_max <= w_sel_m;
                r_rsp_d   <= '0;
            end
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin : rows_reg
        if (rst) begin
            r_rows_done <= '0;
        end else if (r_rsp_valid && rsp_ready && r_rsp_last) begin
            r_rows_done <= r_rows_done + 16'd1;
        end
    end

`ifdef E_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin : stall_reg
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_rsp_valid && !rsp_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_max   = r_rsp_max;
    assign rsp_d     = r_rsp_d;
    assign rsp_last  = r_rsp_last;
    assign rows_done = r_rows_done;

endmodule

`default_nettype wire

// File: tb/tb_e_cmp_sched.sv
// ============================================================================
//  Module   : tb_e_cmp_sched
//  Brief    : Directed plus randomized bench for e_cmp_sched against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e_cmp_sched;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_e_del;
    logic [N*DW-1:0] req_m_del;
    logic [N-1:0]    req_last;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_max;
    logic [BW-1:0]   rsp_d;
    logic            rsp_last;
    logic            busy;
    logic [15:0]     rows_done;
    logic [15:0]     stall_cnt;

    e_cmp_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .BT_WIDTH(BW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_e_del(req_e_del), .req_m_del(req_m_del), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_max(rsp_max), .rsp_d(rsp_d), .rsp_last(rsp_last),
        .busy(busy), .rows_done(rows_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: transaction-level view of the scheduler.
    bit          m_lock;
    int          m_owner, m_ptr, m_id;
    bit          m_rv, m_last;
    logic [15:0] m_max, m_rows, m_stall;
    logic [7:0]  m_d;
    int          rec_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_owner = 0; m_ptr = 0; m_id = 0;
        m_rv = 0; m_last = 0; m_max = 16'hFFFF; m_d = 8'hFF;
        m_rows = 0; m_stall = 0;
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic cycle();
        int g;
        bit has, can;
        logic [N-1:0] exp_rdy;
        logic signed [DW-1:0] e, m;
        #1;
        check_eq("rsp_valid", rsp_valid, m_rv);
        check_eq("busy", busy, m_lock || m_rv);
        check_eq("rows_done", rows_done, m_rows);
        check_eq("stall_cnt", stall_cnt, m_stall);
        if (m_rv) begin
            check_eq("rsp_id", rsp_id, m_id);
            check_eq("rsp_max", rsp_max, m_max);
            check_eq("rsp_d", rsp_d, m_d);
            check_eq("rsp_last", rsp_last, m_last);
        end
        if (rsp_valid && rsp_ready) rec_q.push_back(int'(rsp_id));

        can = !m_rv || rsp_ready;
        has = 0;
        g = 0;
        if (m_lock) begin
            has = 1;
            g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!has && req_valid[(m_ptr + k) % N]) begin
                    has = 1;
                    g = (m_ptr + k) % N;
                end
            end
        end
        exp_rdy = (has && can) ? (N'(1) << g) : '0;
        check_eq("req_ready", req_ready, exp_rdy);

        if (rst) begin
            model_reset();
        end else begin
            if (m_rv && rsp_ready && m_last) m_rows++;
`ifdef E_SCHED_STALL_CNT_EN
            if (m_rv && !rsp_ready && m_stall != 16'hFFFF) m_stall++;
`endif
            if (exp_rdy[g] && req_valid[g]) begin
                e = req_e_del[g*DW +: DW];
                m = req_m_del[g*DW +: DW];
                m_rv = 1; m_id = g; m_last = req_last[g];
                if (e > m) begin m_max = e; m_d = 8'd4; end
                else begin m_max = m; m_d = 8'd0; end
                if (req_last[g]) begin m_lock = 0; m_ptr = (g + 1) % N; end
                else begin m_lock = 1; m_owner = g; end
            end else if (rsp_ready) begin
                m_rv = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send1(input int id, input logic [DW-1:0] e, input logic [DW-1:0] m, input bit last);
        req_valid = '0;
        req_last  = '0;
        req_valid[id] = 1'b1;
        req_last[id]  = last;
        req_e_del[id*DW +: DW] = e;
        req_m_del[id*DW +: DW] = m;
        cycle();
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            req_e_del[i*DW +: DW] = DW'($urandom);
            req_m_del[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? req_e_del[i*DW +: DW] : DW'($urandom);
        end
    endtask

    int exp_lock[4] = '{0, 0, 0, 2};
    int exp_rr[5]   = '{0, 1, 2, 3, 0};
    logic [DW-1:0] held;

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; rsp_ready = 1'b1;
        req_e_del = '0; req_m_del = '0;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("idle_max", rsp_max, 16'hFFFF);
            check_eq("idle_d", rsp_d, 8'hFF);
            check_eq("idle_valid", rsp_valid, 0);
            check_eq("idle_busy", busy, 0);
        end

        send1(1, 16'd5, 16'd3, 1'b1);
        check_eq("s1_valid", rsp_valid, 1);
        check_eq("s1_id", rsp_id, 1);
        check_eq("s1_max", rsp_max, 16'd5);
        check_eq("s1_d", rsp_d, 8'd4);
        check_eq("s1_last", rsp_last, 1);
        cycle();
        check_eq("s1_rows", rows_done, 1);

        send1(0, -16'sd2, -16'sd7, 1'b1);
        check_eq("neg_e_max", rsp_max, 16'hFFFE);
        check_eq("neg_e_d", rsp_d, 8'd4);
        send1(0, -16'sd7, -16'sd2, 1'b1);
        check_eq("neg_m_max", rsp_max, 16'hFFFE);
        check_eq("neg_m_d", rsp_d, 8'd0);
        send1(0, 16'd9, 16'd9, 1'b1);
        check_eq("tie_max", rsp_max, 16'd9);
        check_eq("tie_d", rsp_d, 8'd0);
        send1(3, 16'd1, 16'd2, 1'b1);
        cycle();

        // Lock: req 0 owns a 3-beat burst while req 2 waits.
        rec_q.delete();
        for (int b = 0; b < 3; b++) begin
            rand_data();
            req_valid = 4'b0101;
            req_last  = (b == 2) ? 4'b0101 : 4'b0100;
            #1;
            check_eq("lock_r2_blocked", req_ready[2], 0);
            cycle();
        end
        req_valid = 4'b0100; req_last = 4'b0100;
        cycle();
        req_valid = '0; req_last = '0;
        cycle();
        cycle();
        check_eq("lock_cnt", rec_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq("lock_seq", (i < rec_q.size()) ? rec_q[i] : 99, exp_lock[i]);

        // Round robin with single-beat bursts.
        send1(3, 16'd0, 16'd0, 1'b1);
        cycle();
        rec_q.delete();
        req_valid = 4'hF; req_last = 4'hF;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            cycle();
        end
        req_valid = '0; req_last = '0;
        cycle();
        check_eq("rr_cnt", rec_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check_eq("rr_seq", (i < rec_q.size()) ? rec_q[i] : 99, exp_rr[i]);

        // Backpressure mid-burst.
        req_valid = 4'b0010; req_last = 4'b0000;
        rand_data(); cycle();
        rand_data(); cycle();
        rsp_ready = 1'b0;
        held = rsp_max;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            #1;
            check_eq("bp_ready", req_ready, 0);
            cycle();
            check_eq("bp_hold_max", rsp_max, held);
            check_eq("bp_hold_valid", rsp_valid, 1);
        end
`ifdef E_SCHED_STALL_CNT_EN
        check_eq("bp_stall", stall_cnt, 5);
`else
        check_eq("bp_stall", stall_cnt, 0);
`endif
        rsp_ready = 1'b1;
        rand_data(); cycle();
        req_last = 4'b0010;
        rand_data(); cycle();
        req_valid = '0; req_last = '0;
        cycle(); cycle();

        // Reset in the middle of a burst.
        req_valid = 4'b0100; req_last = 4'b0000;
        rand_data(); cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; req_valid = '0;
        check_eq("rst_valid", rsp_valid, 0);
        check_eq("rst_busy", busy, 0);
        rec_q.delete();
        req_valid = 4'hF; req_last = 4'hF;
        rand_data(); cycle();
        req_valid = '0; req_last = '0;
        cycle();
        check_eq("rst_ptr_n", rec_q.size(), 1);
        check_eq("rst_ptr", (rec_q.size() > 0) ? rec_q[0] : 99, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rand_data();
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) req_last[r] = ($urandom_range(0, 2) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
